// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one slot per digit, blanked at slot start,
// frames double-buffered behind a valid/ready port and committed only at frame boundaries.
module sevenseg_scan_ctrl #(
   parameter int unsigned CLK_DIV    = 10000,
   parameter int unsigned BLANK_CYC  = 16,
   parameter int unsigned NUM_DIGITS = 8,
   localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    LOAD_VALID,
   output logic                    LOAD_READY,
   input  logic [4*NUM_DIGITS-1:0] LOAD_DATA,
   input  logic [NUM_DIGITS-1:0]   LOAD_MASK,
   input  logic [NUM_DIGITS-1:0]   LOAD_DP,
   output logic [7:0]              CA,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [IdxW-1:0]         DIGIT_IDX,
   output logic                    FRAME_DONE
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
   localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_DIGITS - 1);

   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_full_q, pend_full_d;

   logic       frame_done;
   logic       accept;
   logic [3:0] digit_nib;

   // Segment pattern g..a, active low.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      unique case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   assign frame_done = (cnt_q == CntMax) && (idx_q == IdxMax);
   assign accept     = LOAD_VALID && !pend_full_q;

   always_comb begin
      cnt_d       = cnt_q + CntW'(1);
      idx_d       = idx_q;
      act_data_d  = act_data_q;
      act_mask_d  = act_mask_q;
      act_dp_d    = act_dp_q;
      pend_data_d = pend_data_q;
      pend_mask_d = pend_mask_q;
      pend_dp_d   = pend_dp_q;
      pend_full_d = pend_full_q;

      if (cnt_q == CntMax) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
      end

      // Commit and accept are exclusive: one needs pend_full set, the other clear.
      if (frame_done && pend_full_q) begin
         act_data_d  = pend_data_q;
         act_mask_d  = pend_mask_q;
         act_dp_d    = pend_dp_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_data_d = LOAD_DATA;
         pend_mask_d = LOAD_MASK;
         pend_dp_d   = LOAD_DP;
         pend_full_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         act_data_q  <= '0;
         act_mask_q  <= '0;
         act_dp_q    <= '0;
         pend_data_q <= '0;
         pend_mask_q <= '0;
         pend_dp_q   <= '0;
         pend_full_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         act_data_q  <= act_data_d;
         act_mask_q  <= act_mask_d;
         act_dp_q    <= act_dp_d;
         pend_data_q <= pend_data_d;
         pend_mask_q <= pend_mask_d;
         pend_dp_q   <= pend_dp_d;
         pend_full_q <= pend_full_d;
      end
   end

   assign digit_nib = act_data_q[{idx_q, 2'b00} +: 4];

   // Outputs decode registered state only.
   always_comb begin
      AN = '1;
      CA = 8'hFF;
      if ((cnt_q >= BlankEnd) && act_mask_q[idx_q]) begin
         AN = ~(NUM_DIGITS'(1) << idx_q);
         CA = {~act_dp_q[idx_q], hex_to_seg(digit_nib)};
      end
   end

   assign DIGIT_IDX  = idx_q;
   assign FRAME_DONE = frame_done;
   assign LOAD_READY = !pend_full_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a cycle-count reference model queues the expected
// display state each cycle and a negedge monitor compares it against the outputs.
module tb_sevenseg_scan_ctrl;

   localparam int unsigned ClkDiv = 8;
   localparam int unsigned Blank  = 2;
   localparam int unsigned NDig   = 8;
   localparam int unsigned Period = ClkDiv * NDig;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] load_data = '0;
   logic [7:0]  load_mask = '0;
   logic [7:0]  load_dp = '0;
   logic [7:0]  ca;
   logic [7:0]  an;
   logic [2:0]  digit_idx;
   logic        frame_done;

   int vectors = 0;
   int miscompares = 0;

   sevenseg_scan_ctrl #(
      .CLK_DIV   (ClkDiv),
      .BLANK_CYC (Blank),
      .NUM_DIGITS(NDig)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .LOAD_VALID(load_valid),
      .LOAD_READY(load_ready),
      .LOAD_DATA (load_data),
      .LOAD_MASK (load_mask),
      .LOAD_DP   (load_dp),
      .CA        (ca),
      .AN        (an),
      .DIGIT_IDX (digit_idx),
      .FRAME_DONE(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] ca;
      logic [2:0] idx;
      logic       fd;
      logic       rdy;
   } exp_t;

   exp_t sbq[$];

   logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Expected outputs t cycles after reset release, given the frame on display.
   function automatic exp_t calc(input int unsigned t, input logic [31:0] d,
                                 input logic [7:0] m, input logic [7:0] p, input logic pf);
      exp_t        e;
      int unsigned cnt, slot;
      logic [3:0]  nib;
      cnt   = t % ClkDiv;
      slot  = (t / ClkDiv) % NDig;
      e.an  = 8'hFF;
      e.ca  = 8'hFF;
      e.idx = 3'(slot);
      e.fd  = (t % Period) == Period - 1;
      e.rdy = !pf;
      if (cnt >= Blank && m[slot]) begin
         e.an = 8'hFF ^ (8'd1 << slot);
         nib  = d[slot*4 +: 4];
         e.ca = hex_tab[nib];
         if (p[slot]) e.ca[7] = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
      end
   endtask

   // Reference model: frames as opaque values, position derived from elapsed cycles.
   initial begin : model
      int unsigned mt;
      logic [31:0] a_d, p_d;
      logic [7:0]  a_m, a_p, p_m, p_p;
      logic        pf, acc, fd;
      mt = 0; a_d = '0; a_m = '0; a_p = '0; p_d = '0; p_m = '0; p_p = '0; pf = 1'b0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            mt = 0; a_d = '0; a_m = '0; a_p = '0; pf = 1'b0;
            sbq.delete();
            sbq.push_back(calc(0, a_d, a_m, a_p, pf));
         end else begin
            fd  = (mt % Period) == Period - 1;
            acc = load_valid && !pf;
            if (fd && pf) begin
               a_d = p_d; a_m = p_m; a_p = p_p; pf = 1'b0;
            end
            if (acc) begin
               p_d = load_data; p_m = load_mask; p_p = load_dp; pf = 1'b1;
            end
            mt++;
            sbq.push_back(calc(mt, a_d, a_m, a_p, pf));
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
               e = sbq.pop_front();
               chk("an", 32'(an), 32'(e.an));
               chk("ca", 32'(ca), 32'(e.ca));
               chk("digit_idx", 32'(digit_idx), 32'(e.idx));
               chk("frame_done", 32'(frame_done), 32'(e.fd));
               chk("load_ready", 32'(load_ready), 32'(e.rdy));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called aligned at posedge+1; returns aligned at posedge+1 after the accept edge.
   task automatic send(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
      int n;
      load_valid = 1'b1;
      load_data  = d;
      load_mask  = m;
      load_dp    = p;
      n = 0;
      forever begin
         @(negedge clk);
         if (load_ready) begin
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            load_data  = $urandom;
            load_mask  = 8'($urandom);
            load_dp    = 8'($urandom);
            return;
         end
         n++;
         if (n > 4 * Period) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: got ready=0 expected ready=1 at %0t", $time);
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            return;
         end
      end
   endtask

   initial begin : stim
      idle(3);
      chk("reset_an", 32'(an), 32'hFF);
      chk("reset_ca", 32'(ca), 32'hFF);
      #1 rst = 1'b1;
      idle(1);

      // Pending beat held, then reset mid-slot: beat is discarded, outputs dark at once.
      send(32'h1234_5678, 8'hFF, 8'hFF);
      load_valid = 1'b1;
      idle(10);
      #1;
      rst = 1'b0;
      load_valid = 1'b0;
      #1;
      chk("async_rst_an", 32'(an), 32'hFF);
      chk("async_rst_ca", 32'(ca), 32'hFF);
      chk("async_rst_ready", 32'(load_ready), 32'h1);
      chk("async_rst_idx", 32'(digit_idx), 32'h0);
      chk("async_rst_fd", 32'(frame_done), 32'h0);
      #1 rst = 1'b1;
      idle(1);
      idle(2 * Period + 5);

      send(32'h0000_0041, 8'hFF, 8'h00);
      idle(2 * Period);

      send(32'hABCD_EF01, 8'hFF, 8'h5A);
      send(32'h2345_6789, 8'hF0, 8'h0F);
      idle(3 * Period);

      send(32'h8765_4321, 8'h0F, 8'h00);
      idle(3 * Period);

      send(32'h0000_8000, 8'hFF, 8'h08);
      idle(2 * Period);

      send(32'h7654_3210, 8'hFF, 8'h00);
      idle(Period);
      send(32'hFEDC_BA98, 8'hFF, 8'h00);
      idle(2 * Period);

      for (int i = 0; i < 8; i++) begin
         send($urandom, 8'($urandom), 8'($urandom));
         idle(int'($urandom_range(0, 2 * Period)));
      end
      idle(2 * Period);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
